// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch controller.
package fetch_pkg;
  localparam int INSTR_W = 32;
  localparam int OFFS_W  = 16;

  localparam logic PC_SEL_SEQ = 1'b0;
  localparam logic PC_SEL_BR  = 1'b1;

  typedef enum logic [1:0] {
    S_BOOT,
    S_REQ,
    S_HOLD
  } state_t;
endpackage

// File: rtl/fetch_ctrl_if.sv
// Request/ready handshake between the fetch controller and instruction memory.
interface fetch_ctrl_if;
  import fetch_pkg::*;

  logic               mem_req;
  logic               mem_rdy;
  logic [INSTR_W-1:0] mem_rdata;

  modport master (output mem_req, input mem_rdy, input mem_rdata);
  modport slave  (input mem_req, output mem_rdy, output mem_rdata);
endinterface

// File: rtl/fetch_wait_timer.sv
// Counts unanswered request cycles and raises a sticky timeout flag at WAIT_LIMIT.
module fetch_wait_timer #(
  parameter int WAIT_LIMIT = 255,
  parameter int CNT_W      = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic waiting,
  output logic fetch_err
);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(WAIT_LIMIT);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;

  // Saturate at the limit so a stuck memory never wraps the counter.
  always_comb begin
    cnt_next = '0;
    if (waiting) cnt_next = (cnt == LIMIT) ? cnt : cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt       <= '0;
      fetch_err <= 1'b0;
    end else begin
      cnt <= cnt_next;
      if (waiting && (cnt_next == LIMIT)) fetch_err <= 1'b1;
    end
  end
endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencing controller with skid buffer and deferred branch redirect.
// Optional macro FETCH_PERF_EN adds perf_fetch/perf_stall/perf_wait counters.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int WAIT_LIMIT = 255,
  parameter int CNT_W      = 8
) (
  input  logic               clk,
  input  logic               rst,
  fetch_ctrl_if.master       mem,
  input  logic               hazard_stall,
  input  logic               br_taken,
  input  logic [OFFS_W-1:0]  br_offset_in,
  output logic               pc_en,
  output logic               pc_sel,
  output logic [OFFS_W-1:0]  br_offset_out,
  output logic               if_id_en,
  output logic               if_id_flush,
  output logic [INSTR_W-1:0] instr_out,
  output logic               fetch_err
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]        perf_fetch,
  output logic [31:0]        perf_stall,
  output logic [31:0]        perf_wait
`endif
);
  state_t             state;
  logic               br_pending;
  logic [OFFS_W-1:0]  offs_q;
  logic [INSTR_W-1:0] skid;
  logic               in_req;
  logic               in_hold;
  logic               waiting;
  logic               redirect;

  assign in_req      = (state == S_REQ);
  assign in_hold     = (state == S_HOLD);
  assign mem.mem_req = in_req;
  assign waiting     = in_req && !mem.mem_rdy;

  // A redirect fires once the outstanding access is closed, or at once from the skid state.
  assign redirect = (in_req && mem.mem_rdy && (br_taken || br_pending)) ||
                    (in_hold && br_taken);

  always_comb begin
    pc_en       = 1'b0;
    pc_sel      = PC_SEL_SEQ;
    if_id_en    = 1'b0;
    if_id_flush = 1'b0;
    if (redirect) begin
      pc_en       = 1'b1;
      pc_sel      = PC_SEL_BR;
      if_id_flush = 1'b1;
    end else if (in_req && br_taken) begin
      if_id_flush = 1'b1;
    end else if (((in_req && mem.mem_rdy) || in_hold) && !hazard_stall) begin
      pc_en    = 1'b1;
      if_id_en = 1'b1;
    end
  end

  assign br_offset_out = (redirect && br_taken) ? br_offset_in : offs_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_BOOT;
      br_pending <= 1'b0;
      offs_q     <= '0;
      skid       <= '0;
      instr_out  <= '0;
    end else begin
      case (state)
        S_BOOT: state <= S_REQ;
        S_REQ: begin
          if (br_taken) offs_q <= br_offset_in;
          if (mem.mem_rdy) begin
            br_pending <= 1'b0;
            if (!(br_taken || br_pending)) begin
              instr_out <= mem.mem_rdata;
              if (hazard_stall) begin
                skid  <= mem.mem_rdata;
                state <= S_HOLD;
              end
            end
          end else if (br_taken) begin
            br_pending <= 1'b1;
          end
        end
        S_HOLD: begin
          instr_out <= skid;
          if (br_taken) begin
            offs_q <= br_offset_in;
            state  <= S_REQ;
          end else if (!hazard_stall) begin
            state <= S_REQ;
          end
        end
        default: state <= S_BOOT;
      endcase
    end
  end

  fetch_wait_timer #(
    .WAIT_LIMIT(WAIT_LIMIT),
    .CNT_W     (CNT_W)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .waiting  (waiting),
    .fetch_err(fetch_err)
  );

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_fetch <= '0;
      perf_stall <= '0;
      perf_wait  <= '0;
    end else begin
      if (if_id_en) perf_fetch <= perf_fetch + 32'd1;
      if (in_hold)  perf_stall <= perf_stall + 32'd1;
      if (waiting)  perf_wait  <= perf_wait + 32'd1;
    end
  end
`endif
endmodule
